// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, exception codes and the ES->MS bus field layout.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 125;
    localparam int MS_TO_WS_BUS_WD = 117;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    typedef struct packed {
        logic        eret;
        logic        bd;
        logic        mtc0_we;
        logic [4:0]  cp0_addr;
        logic        ex;
        logic [4:0]  excode;
        logic        res_from_cp0;
        logic        lwl;
        logic        lwr;
        logic [31:0] rt;
        logic        ld_w;
        logic        ld_h;
        logic        ld_b;
        logic        ld_sign;
        logic [1:0]  whb;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_res;
        logic [31:0] pc;
    } es_to_ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_load_align: aligns, extends and (with MS_LWLR_EN) merges load data by byte offset.
module mem_load_align (
    input  logic [31:0] data,
    input  logic [31:0] rt,
    input  logic [1:0]  whb,
    input  logic        ld_w,
    input  logic        ld_h,
    input  logic        ld_b,
    input  logic        ld_sign,
    input  logic        lwl,
    input  logic        lwr,
    output logic [31:0] result
);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] base;

    assign h    = whb[1] ? data[31:16] : data[15:0];
    assign b    = data[{whb, 3'b000} +: 8];
    assign base = ld_w ? data
                : ld_h ? {{16{ld_sign & h[15]}}, h}
                : ld_b ? {{24{ld_sign & b[7]}}, b}
                : data;

`ifdef MS_LWLR_EN
    logic [31:0] l, r;

    assign l = whb == 2'd0 ? {data[7:0],  rt[23:0]}
             : whb == 2'd1 ? {data[15:0], rt[15:0]}
             : whb == 2'd2 ? {data[23:0], rt[7:0]}
             : data;
    assign r = whb == 2'd0 ? data
             : whb == 2'd1 ? {rt[31:24], data[31:8]}
             : whb == 2'd2 ? {rt[31:16], data[31:16]}
             : {rt[31:8], data[31:24]};
    assign result = lwl ? l : lwr ? r : base;
`else
    logic lwlr_unused;

    assign lwlr_unused = ^{lwl, lwr, rt};
    assign result      = base;
`endif
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; registers ES->MS bus, buffers SRAM load data across stalls, builds MS->WS bus.
// Define MS_LWLR_EN to enable lwl/lwr merge support.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ex_from_ws,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [31:0]                ms_forward,
    output logic [4:0]                 ms_to_es_addr,
    output logic                       ms_load_h,
    output logic                       ms_res_from_cp0_h,
    output logic                       ex_from_ms,
    output logic                       ms_valid_h
);
    es_to_ms_t   es_r;
    logic        ms_valid, ld_buf_vld, is_load;
    logic [31:0] ld_buf, ld_data, ld_res, result, badvaddr;

    assign ms_allowin = !ms_valid || ws_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid   <= 1'b0;
            es_r       <= '0;
            ld_buf     <= '0;
            ld_buf_vld <= 1'b0;
        end else begin
            ms_valid <= ex_from_ws ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid;
            if (es_to_ms_valid && ms_allowin) begin
                es_r       <= es_to_ms_t'(es_to_ms_bus);
                ld_buf_vld <= 1'b0;
            end else if (ms_valid && is_load && !ld_buf_vld) begin
                // ES re-reads SRAM while we stall, so hold the first-cycle data
                ld_buf     <= data_sram_rdata;
                ld_buf_vld <= 1'b1;
            end
        end
    end

`ifdef MS_LWLR_EN
    assign is_load = es_r.ld_w | es_r.ld_h | es_r.ld_b | es_r.lwl | es_r.lwr;
`else
    assign is_load = es_r.ld_w | es_r.ld_h | es_r.ld_b;
`endif

    assign ld_data = ld_buf_vld ? ld_buf : data_sram_rdata;

    mem_load_align u_align (
        .data    (ld_data),
        .rt      (es_r.rt),
        .whb     (es_r.whb),
        .ld_w    (es_r.ld_w),
        .ld_h    (es_r.ld_h),
        .ld_b    (es_r.ld_b),
        .ld_sign (es_r.ld_sign),
        .lwl     (es_r.lwl),
        .lwr     (es_r.lwr),
        .result  (ld_res)
    );

    assign result   = is_load ? ld_res : es_r.alu_res;
    assign badvaddr = (es_r.excode == EXC_ADEL || es_r.excode == EXC_ADES) ? es_r.alu_res : 32'h0;

    assign ms_to_ws_valid    = ms_valid;
    assign ms_to_ws_bus      = {es_r.eret, es_r.bd, es_r.mtc0_we, es_r.cp0_addr, es_r.ex, es_r.excode,
                                es_r.res_from_cp0, es_r.gr_we & !es_r.ex, es_r.dest, result, badvaddr, es_r.pc};
    assign ms_forward        = result;
    assign ms_to_es_addr     = (ms_valid && es_r.gr_we) ? es_r.dest : 5'd0;
    assign ms_load_h         = ms_valid & is_load;
    assign ms_res_from_cp0_h = ms_valid & es_r.res_from_cp0;
    assign ex_from_ms        = ms_valid & es_r.ex;
    assign ms_valid_h        = ms_valid;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven scoreboard bench for mem_stage plus stall, flush and reset sequences.
module tb_mem_stage;
    logic         clk = 1'b0;
    logic         resetn, ws_allowin, ms_allowin, es_to_ms_valid, ex_from_ws;
    logic [124:0] es_to_ms_bus;
    logic [31:0]  data_sram_rdata;
    logic         ms_to_ws_valid;
    logic [116:0] ms_to_ws_bus;
    logic [31:0]  ms_forward;
    logic [4:0]   ms_to_es_addr;
    logic         ms_load_h, ms_res_from_cp0_h, ex_from_ms, ms_valid_h;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [124:0] bus;
        logic [31:0]  rdata;
        logic [31:0]  r;
        logic         gw;
        logic [31:0]  bv;
        logic         ld;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ex_from_ws        (ex_from_ws),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_forward        (ms_forward),
        .ms_to_es_addr     (ms_to_es_addr),
        .ms_load_h         (ms_load_h),
        .ms_res_from_cp0_h (ms_res_from_cp0_h),
        .ex_from_ms        (ex_from_ms),
        .ms_valid_h        (ms_valid_h)
    );

    // side = {eret, bd, mtc0_we, cp0_addr[4:0], res_from_cp0}; fl = {ld_w, ld_h, ld_b, ld_sign}
    function automatic logic [124:0] mk(input logic [8:0] side, input logic ex, input logic [4:0] excode,
                                        input logic lwl, input logic lwr, input logic [31:0] rt,
                                        input logic [3:0] fl, input logic [1:0] whb, input logic gw,
                                        input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc);
        return {side[8:1], ex, excode, side[0], lwl, lwr, rt, fl, whb, gw, dest, alu, pc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        @(negedge clk);
        es_to_ms_bus   = v.bus;
        es_to_ms_valid = 1'b1;
        ws_allowin     = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = v.rdata;
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("valid",    {31'd0, ms_to_ws_valid},   32'd1);
        chk("result",   ms_to_ws_bus[95:64],        e.r);
        chk("forward",  ms_forward,                 e.r);
        chk("gr_we",    {31'd0, ms_to_ws_bus[101]}, {31'd0, e.gw});
        chk("badvaddr", ms_to_ws_bus[63:32],        e.bv);
        chk("pc",       ms_to_ws_bus[31:0],         e.bus[31:0]);
        chk("side",     {23'd0, ms_to_ws_bus[116:109], ms_to_ws_bus[102]}, {23'd0, e.bus[124:117], e.bus[110]});
        chk("excode",   {27'd0, ms_to_ws_bus[107:103]}, {27'd0, e.bus[115:111]});
        chk("ex_ms",    {31'd0, ex_from_ms},        {31'd0, e.bus[116]});
        chk("load_h",   {31'd0, ms_load_h},         {31'd0, e.ld});
        chk("cp0_h",    {31'd0, ms_res_from_cp0_h}, {31'd0, e.bus[110]});
        if (!e.bus[116])
            chk("es_addr", {27'd0, ms_to_es_addr}, e.bus[69] ? {27'd0, e.bus[68:64]} : 32'd0);
    endtask

    initial begin
        resetn          = 1'b0;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        ex_from_ws      = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = 32'h5A5A_5A5A;

        tbl.push_back('{mk(9'h0, 0, 5'h00, 0, 0, 32'h0, 4'b0011, 2'd3, 1, 5'd5,  32'h103, 32'hBFC0_0000), 32'h80FF_1234, 32'hFFFF_FF80, 1'b1, 32'h0, 1'b1});
        tbl.push_back('{mk(9'h0, 0, 5'h00, 0, 0, 32'h0, 4'b0010, 2'd1, 1, 5'd6,  32'h201, 32'hBFC0_0004), 32'h0000_F100, 32'h0000_00F1, 1'b1, 32'h0, 1'b1});
        tbl.push_back('{mk(9'h0, 0, 5'h00, 0, 0, 32'h0, 4'b0101, 2'd2, 1, 5'd7,  32'h302, 32'hBFC0_0008), 32'h8001_0000, 32'hFFFF_8001, 1'b1, 32'h0, 1'b1});
        tbl.push_back('{mk(9'h0, 0, 5'h00, 0, 0, 32'h0, 4'b0100, 2'd0, 1, 5'd8,  32'h400, 32'hBFC0_000C), 32'h1234_BEEF, 32'h0000_BEEF, 1'b1, 32'h0, 1'b1});
        tbl.push_back('{mk(9'h0, 0, 5'h00, 0, 0, 32'h0, 4'b1000, 2'd0, 1, 5'd9,  32'h500, 32'hBFC0_0010), 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b1});
        tbl.push_back('{mk(9'b110000111, 0, 5'h00, 0, 0, 32'h0, 4'b0000, 2'd0, 1, 5'd10, 32'h1234_5678, 32'hBFC0_0014), 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 32'h0, 1'b0});
        tbl.push_back('{mk(9'h0, 1, 5'h04, 0, 0, 32'h0, 4'b0000, 2'd1, 1, 5'd11, 32'h1001, 32'hBFC0_0018), 32'h0, 32'h1001, 1'b0, 32'h1001, 1'b0});
        tbl.push_back('{mk(9'h0, 1, 5'h08, 0, 0, 32'h0, 4'b0000, 2'd2, 1, 5'd12, 32'h2222, 32'hBFC0_001C), 32'h0, 32'h2222, 1'b0, 32'h0, 1'b0});
        tbl.push_back('{mk(9'b010000000, 1, 5'h05, 0, 0, 32'h0, 4'b0000, 2'd3, 0, 5'd13, 32'h3003, 32'hBFC0_0020), 32'h0, 32'h3003, 1'b0, 32'h3003, 1'b0});
`ifdef MS_LWLR_EN
        tbl.push_back('{mk(9'h0, 0, 5'h00, 1, 0, 32'h1122_3344, 4'b0000, 2'd1, 1, 5'd14, 32'h1001, 32'hBFC0_0024), 32'hAABB_CCDD, 32'hCCDD_3344, 1'b1, 32'h0, 1'b1});
        tbl.push_back('{mk(9'h0, 0, 5'h00, 0, 1, 32'h1122_3344, 4'b0000, 2'd2, 1, 5'd15, 32'h1002, 32'hBFC0_0028), 32'hAABB_CCDD, 32'h1122_AABB, 1'b1, 32'h0, 1'b1});
        tbl.push_back('{mk(9'h0, 0, 5'h00, 1, 0, 32'h1122_3344, 4'b0000, 2'd0, 1, 5'd16, 32'h1000, 32'hBFC0_002C), 32'hAABB_CCDD, 32'hDD22_3344, 1'b1, 32'h0, 1'b1});
        tbl.push_back('{mk(9'h0, 0, 5'h00, 0, 1, 32'h1122_3344, 4'b0000, 2'd3, 1, 5'd17, 32'h1003, 32'hBFC0_0030), 32'hAABB_CCDD, 32'h1122_33AA, 1'b1, 32'h0, 1'b1});
        tbl.push_back('{mk(9'h0, 0, 5'h00, 1, 0, 32'h1122_3344, 4'b0000, 2'd3, 1, 5'd18, 32'h1007, 32'hBFC0_0034), 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b1, 32'h0, 1'b1});
`else
        tbl.push_back('{mk(9'h0, 0, 5'h00, 1, 0, 32'h1122_3344, 4'b0000, 2'd1, 1, 5'd14, 32'h1001, 32'hBFC0_0024), 32'hAABB_CCDD, 32'h1001, 1'b1, 32'h0, 1'b0});
        tbl.push_back('{mk(9'h0, 0, 5'h00, 0, 1, 32'h1122_3344, 4'b0000, 2'd2, 1, 5'd15, 32'h1002, 32'hBFC0_0028), 32'hAABB_CCDD, 32'h1002, 1'b1, 32'h0, 1'b0});
`endif

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_allowin", {31'd0, ms_allowin},     32'd1);
        chk("rst_valid",   {31'd0, ms_to_ws_valid}, 32'd0);
        chk("rst_bus",     {31'd0, |ms_to_ws_bus},  32'd0);
        chk("rst_side",    {26'd0, ms_valid_h, ms_load_h, ms_res_from_cp0_h, ex_from_ms, |ms_forward, |ms_to_es_addr}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i]);

        // lh unsigned held across a WS stall while SRAM data changes
        @(negedge clk);
        es_to_ms_bus   = mk(9'h0, 0, 5'h00, 0, 0, 32'h0, 4'b0100, 2'd2, 1, 5'd20, 32'h0802, 32'hBFC0_0100);
        es_to_ms_valid = 1'b1;
        @(negedge clk);
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'hBEEF_0000;
        #1;
        chk("stall_first", ms_to_ws_bus[95:64], 32'h0000_BEEF);
        ws_allowin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            data_sram_rdata = 32'h0;
            es_to_ms_bus    = mk(9'h0, 0, 5'h00, 0, 0, 32'h0, 4'b0000, 2'd0, 1, 5'd21, 32'hFFFF, 32'hBFC0_0104);
            es_to_ms_valid  = 1'b1;
            #1;
            chk("stall_hold",    ms_to_ws_bus[95:64],        32'h0000_BEEF);
            chk("stall_allowin", {31'd0, ms_allowin},        32'd0);
            chk("stall_valid",   {31'd0, ms_to_ws_valid},    32'd1);
        end
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b1;
        @(negedge clk);
        #1;
        chk("stall_drain", {31'd0, ms_valid_h}, 32'd0);

        // WS flush in the same cycle as an ES->MS transfer
        @(negedge clk);
        es_to_ms_bus   = mk(9'h0, 0, 5'h00, 0, 0, 32'h0, 4'b1000, 2'd0, 1, 5'd22, 32'h0900, 32'hBFC0_0200);
        es_to_ms_valid = 1'b1;
        ex_from_ws     = 1'b1;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        ex_from_ws     = 1'b0;
        #1;
        chk("flush_valid",   {31'd0, ms_valid_h},     32'd0);
        chk("flush_ws",      {31'd0, ms_to_ws_valid}, 32'd0);
        chk("flush_load_h",  {31'd0, ms_load_h},      32'd0);

        // async reset while a load is stalled in MS
        @(negedge clk);
        es_to_ms_bus   = mk(9'h0, 0, 5'h00, 0, 0, 32'h0, 4'b1000, 2'd0, 1, 5'd23, 32'h0A00, 32'hBFC0_0300);
        es_to_ms_valid = 1'b1;
        @(negedge clk);
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h1111_1111;
        ws_allowin      = 1'b0;
        @(posedge clk);
        #3;
        chk("pre_rst_addr", {27'd0, ms_to_es_addr}, 32'd23);
        resetn = 1'b0;
        #1;
        chk("mrst_valid",   {31'd0, ms_valid_h},    32'd0);
        chk("mrst_allowin", {31'd0, ms_allowin},    32'd1);
        chk("mrst_addr",    {27'd0, ms_to_es_addr}, 32'd0);
        chk("mrst_bus",     {31'd0, |ms_to_ws_bus}, 32'd0);
        @(negedge clk);
        resetn     = 1'b1;
        ws_allowin = 1'b1;
        run_vec('{mk(9'h0, 0, 5'h00, 0, 0, 32'h0, 4'b1000, 2'd0, 1, 5'd24, 32'h0B00, 32'hBFC0_0304), 32'h2222_2222, 32'h2222_2222, 1'b1, 32'h0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
